spi_slave_drive: RTL and testbench

SPI mode-0 (CPOL=0, CPHA=0) responder that is the far end of the team's SPI master driver: it receives MSB-first bytes on MOSI and returns MSB-first bytes on MISO. It sits on the FPGA side of a board-to-board SPI link. SCLK, CS and MOSI are oversampled in the single system clock domain. User logic exchanges bytes through one-deep valid/ready holding registers.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 47 ++++
 rtl/spi_slave_drive.sv | 199 +++++++++++++++++++
 tb/tb_spi_slave_drive.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared types and constants for the SPI mode-0 responder
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int SPI_BITS = 8;
  localparam int CNT_W    = $clog2(SPI_BITS);

  localparam logic [SPI_BITS-1:0] IDLE_BYTE_DEF = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// spi_sync_edge : N-flop synchronizer, history flop and registered rise/fall
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic lvl_o,
  output logic dly_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic                   fall_q;

  // Events are registered so they line up with dly_o, the history flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

  assign lvl_o  = sync_q[SYNC_STAGES-1];
  assign dly_o  = hist_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_drive.sv
// ============================================================================
// spi_slave_drive : oversampled SPI mode-0 responder with 1-deep TX/RX buffers
// Optional sticky error flags: define SPI_SLAVE_STATUS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_slave_drive
  import spi_pkg::*;
#(
  parameter logic [SPI_BITS-1:0] IDLE_BYTE   = IDLE_BYTE_DEF,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                spi_sclk,
  input  logic                spi_cs,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  input  logic [SPI_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                cs_active,
  input  logic                status_clr,
  output logic                ovr_err,
  output logic                udr_err
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_lvl, mosi_s;
  logic unused_sclk_lvl, unused_sclk_dly, unused_cs_dly;
  logic unused_mosi_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(sys_clk), .rst_i(sys_rst), .d_i(spi_sclk),
    .lvl_o(unused_sclk_lvl), .dly_o(unused_sclk_dly),
    .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // CS idles high, so its chain resets high to avoid a false cs_fall.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(sys_clk), .rst_i(sys_rst), .d_i(spi_cs),
    .lvl_o(cs_lvl), .dly_o(unused_cs_dly),
    .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(sys_clk), .rst_i(sys_rst), .d_i(spi_mosi),
    .lvl_o(unused_mosi_lvl), .dly_o(mosi_s),
    .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  state_e              state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [SPI_BITS-1:0] tx_shift_q;
  logic [SPI_BITS-1:0] rx_shift_q;
  logic                miso_q;
  logic                miso_oe_q;
  logic [SPI_BITS-1:0] tx_buf_q;
  logic                tx_full_q;
  logic [SPI_BITS-1:0] rx_data_q;
  logic                rx_valid_q;

  logic                load_pt;
  logic                byte_done;
  logic                tx_wr;
  logic                rx_accept;
  logic                ovr_set;
  logic                udr_set;
  logic [SPI_BITS-1:0] load_byte;
  logic [SPI_BITS-1:0] rx_next;

  always_comb begin
    load_pt   = 1'b0;
    byte_done = 1'b0;
    load_byte = tx_full_q ? tx_buf_q : IDLE_BYTE;
    rx_next   = {rx_shift_q[SPI_BITS-2:0], mosi_s};
    if (state_q == ST_IDLE) begin
      load_pt = cs_fall;
    end else if (!cs_rise) begin
      load_pt   = sclk_fall && (bit_cnt_q == '0);
      byte_done = sclk_rise && (bit_cnt_q == CNT_W'(SPI_BITS - 1));
    end
    tx_wr     = tx_valid && !tx_full_q;
    rx_accept = !rx_valid_q || rx_ready;
    udr_set   = load_pt && !tx_full_q;
    ovr_set   = byte_done && !rx_accept;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          bit_cnt_q <= '0;
          if (cs_fall) begin
            tx_shift_q <= load_byte;
            miso_q     <= load_byte[SPI_BITS-1];
            miso_oe_q  <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state_q    <= ST_IDLE;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
          end else begin
            if (sclk_rise) begin
              rx_shift_q <= rx_next;
              bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
            end
            if (load_pt) begin
              tx_shift_q <= load_byte;
              miso_q     <= load_byte[SPI_BITS-1];
            end else if (sclk_fall) begin
              tx_shift_q <= {tx_shift_q[SPI_BITS-2:0], 1'b0};
              miso_q     <= tx_shift_q[SPI_BITS-2];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (tx_wr) begin
        tx_buf_q  <= tx_data;
        tx_full_q <= 1'b1;
      end else if (load_pt) begin
        tx_full_q <= 1'b0;
      end
      // A byte arriving while the old one is unclaimed is dropped.
      if (byte_done) begin
        if (rx_accept) begin
          rx_data_q  <= rx_next;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  logic ovr_q;
  logic udr_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      if (ovr_set)         ovr_q <= 1'b1;
      else if (status_clr) ovr_q <= 1'b0;
      if (udr_set)         udr_q <= 1'b1;
      else if (status_clr) udr_q <= 1'b0;
    end
  end

  assign ovr_err = ovr_q;
  assign udr_err = udr_q;
`else
  logic unused_status;
  assign unused_status = status_clr ^ ovr_set ^ udr_set;
  assign ovr_err       = 1'b0;
  assign udr_err       = 1'b0;
`endif

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign tx_ready    = ~tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign cs_active   = ~cs_lvl;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_drive.sv
// ============================================================================
// tb_spi_slave_drive : directed bench for spi_slave_drive (mode-0 master model)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_drive;

  localparam int HALF = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       cs_active;
  logic       status_clr = 1'b0;
  logic       ovr_err;
  logic       udr_err;

  int checks = 0;
  int fails  = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         rx_auto = 1'b1;
  logic       flag_exp;
  logic [7:0] m;

  spi_slave_drive dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cs_active(cs_active), .status_clr(status_clr),
    .ovr_err(ovr_err), .udr_err(udr_err)
  );

  always #5 sys_clk = ~sys_clk;

  // User side runs on the falling edge: refill TX from txq, drain RX into rxq.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      rx_ready = rx_auto && rx_valid;
      if (rx_ready) rxq.push_back(rx_data);
      if (tx_ready && txq.size() > 0) begin
        tx_data  = txq.pop_front();
        tx_valid = 1'b1;
      end else begin
        tx_valid = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    return (rxq.size() > i) ? rxq[i] : 8'hxx;
  endfunction

  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] mo);
    mo = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      tick(HALF);
      mo[i]    = spi_miso;
      spi_sclk = 1'b1;
      tick(HALF);
      spi_sclk = 1'b0;
    end
    tick(HALF);
  endtask

  task automatic frame_end();
    spi_cs = 1'b1;
    tick(HALF + 4);
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    tick(1);
    status_clr = 1'b0;
    tick(1);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_miso"},      spi_miso, 0);
    check({pfx, "_miso_oe"},   spi_miso_oe, 0);
    check({pfx, "_rx_data"},   rx_data, 0);
    check({pfx, "_rx_valid"},  rx_valid, 0);
    check({pfx, "_tx_ready"},  tx_ready, 1);
    check({pfx, "_cs_active"}, cs_active, 0);
    check({pfx, "_ovr"},       ovr_err, 0);
    check({pfx, "_udr"},       udr_err, 0);
  endtask

  initial begin
`ifdef SPI_SLAVE_STATUS_EN
    flag_exp = 1'b1;
`else
    flag_exp = 1'b0;
`endif
    tick(4);
    sys_rst = 1'b0;
    tick(4);
    check_reset_vals("reset");

    // Single frame: A5 preloaded, master sends 3C
    txq.push_back(8'hA5);
    tick(2);
    check("single_tx_ready_low", tx_ready, 0);
    spi_cs = 1'b0;
    tick(6);
    check("single_tx_ready_at_csfall", tx_ready, 1);
    check("single_oe", spi_miso_oe, 1);
    check("single_cs_active", cs_active, 1);
    xfer(8'h3C, 8, m);
    check("single_miso", m, 8'hA5);
    frame_end();
    check("single_rx_count", rxq.size(), 1);
    check("single_rx_byte", rx_at(0), 8'h3C);
    check("single_oe_after", spi_miso_oe, 0);
    check("single_trailing_udr", udr_err, flag_exp);
    pulse_clr();
    check("single_udr_cleared", udr_err, 0);

    // Back-to-back: three bytes, user refilling TX
    rxq.delete();
    txq = {8'h11, 8'h22, 8'h33, 8'h44};
    tick(2);
    spi_cs = 1'b0;
    xfer(8'h01, 8, m);
    check("b2b_miso0", m, 8'h11);
    xfer(8'h02, 8, m);
    check("b2b_miso1", m, 8'h22);
    xfer(8'h03, 8, m);
    check("b2b_miso2", m, 8'h33);
    frame_end();
    check("b2b_rx_count", rxq.size(), 3);
    check("b2b_rx0", rx_at(0), 8'h01);
    check("b2b_rx1", rx_at(1), 8'h02);
    check("b2b_rx2", rx_at(2), 8'h03);
    check("b2b_udr", udr_err, 0);

    // Underrun: TX empty at cs_fall
    rxq.delete();
    spi_cs = 1'b0;
    xfer(8'h5A, 8, m);
    check("udr_miso_idle", m, 8'hFF);
    frame_end();
    check("udr_flag", udr_err, flag_exp);
    check("udr_rx", rx_at(0), 8'h5A);
    pulse_clr();
    check("udr_cleared", udr_err, 0);

    // Overrun: rx_ready held low across two bytes
    rxq.delete();
    rx_auto = 1'b0;
    spi_cs = 1'b0;
    xfer(8'h55, 8, m);
    xfer(8'hAA, 8, m);
    frame_end();
    check("ovr_rx_data_kept", rx_data, 8'h55);
    check("ovr_rx_valid_held", rx_valid, 1);
    check("ovr_flag", ovr_err, flag_exp);
    rx_auto = 1'b1;
    tick(3);
    check("ovr_drain_count", rxq.size(), 1);
    check("ovr_drain_byte", rx_at(0), 8'h55);
    check("ovr_rx_valid_clear", rx_valid, 0);
    pulse_clr();
    check("ovr_cleared", ovr_err, 0);
    check("ovr_udr_cleared", udr_err, 0);

    // Aborted byte: CS rises after 5 bits
    rxq.delete();
    spi_cs = 1'b0;
    xfer(8'hE7, 5, m);
    frame_end();
    check("abort_no_rx", rxq.size(), 0);
    check("abort_rx_valid", rx_valid, 0);
    spi_cs = 1'b0;
    xfer(8'hC3, 8, m);
    frame_end();
    check("abort_next_count", rxq.size(), 1);
    check("abort_next_byte", rx_at(0), 8'hC3);

    // Reset mid-frame at bit_cnt=4
    rxq.delete();
    txq.push_back(8'h5A);
    tick(2);
    spi_cs = 1'b0;
    xfer(8'hF0, 4, m);
    sys_rst = 1'b1;
    spi_cs  = 1'b1;
    tick(3);
    sys_rst = 1'b0;
    tick(6);
    check_reset_vals("midrst");
    txq.push_back(8'h96);
    tick(2);
    spi_cs = 1'b0;
    xfer(8'h69, 8, m);
    check("midrst_miso", m, 8'h96);
    frame_end();
    check("midrst_rx_count", rxq.size(), 1);
    check("midrst_rx_byte", rx_at(0), 8'h69);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
